apb_slave_regfile: RTL and testbench

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_reg_bank.sv | 41 ++++
 rtl/apb_slave_regfile.sv | 131 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file slice.
//   apb_state_e  : APB slave transfer FSM states (IDLE, SETUP, ACCESS)
//   APB_ADDR_W   : default APB address width
//   APB_DATA_W   : default APB data width
//   APB_REG_NUM  : default number of registers in the bank
package apb_pkg;

  localparam int unsigned APB_ADDR_W  = 32;
  localparam int unsigned APB_DATA_W  = 32;
  localparam int unsigned APB_REG_NUM = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// Register array behind the APB slave.
//   clk, rst_n : clock, asynchronous active-low reset (clears every register)
//   we         : write enable, commits wdata into regs[widx] at the rising edge
//   widx/wdata : write index and data
//   ridx/rdata : combinational read port
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned REG_NUM = APB_REG_NUM,
  parameter int unsigned IDX_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (32'(widx) < REG_NUM)) begin
      regs[widx] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(ridx) < REG_NUM) begin
      rdata = regs[ridx];
    end
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave exposing REG_NUM word registers starting at BASE_ADDR.
//   clk, rst_n      : clock, asynchronous active-low reset
//   psel, penable   : APB select / access-phase marker
//   pwrite          : 1 = write, 0 = read
//   paddr, pwdata   : byte address (bits [1:0] ignored), write data
//   prdata          : read data, nonzero only in the pready cycle of a read
//   pready          : one-cycle transfer completion, WAIT_CYCLES+1 ACCESS cycles after SETUP
//   pslverr         : out-of-range flag alongside pready when APB_SLVERR_EN is defined,
//                     otherwise tied to 0
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       REG_NUM     = APB_REG_NUM,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(4 * REG_NUM);

  apb_state_e        state_q, state_cur, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done;

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // SETUP is the cycle in which the bus presents psel=1/penable=0 while the
  // FSM is otherwise idle, so it is resolved combinationally from IDLE and
  // never held in the state register. This lets a new setup phase directly
  // follow the pready cycle without losing a bus cycle.
  always_comb begin
    state_cur = state_q;
    if (state_q == IDLE && psel && !penable) begin
      state_cur = SETUP;
    end

    state_d = state_cur;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done    = 1'b0;

    case (state_cur)
      IDLE: state_d = IDLE;
      SETUP: begin
        addr_d  = paddr;
        write_d = pwrite;
        wdata_d = pwdata;
        cnt_d   = CNT_W'(WAIT_CYCLES);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx      = offset[IDX_W+1:2];

  apb_reg_bank #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W)
  ) u_reg_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (done && write_q && in_range),
    .widx  (idx),
    .wdata (wdata_q),
    .ridx  (idx),
    .rdata (rdata)
  );

  assign pready = done;
  assign prdata = (done && !write_q && in_range) ? rdata : '0;

`ifdef APB_SLVERR_EN
  assign pslverr = done && !in_range;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel1, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata1, prdata3;
  logic        pready1, pready3, pslverr1, pslverr3;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference register contents per instance (0: WAIT_CYCLES=1, 1: WAIT_CYCLES=3)
  logic [31:0] model1 [8];
  logic [31:0] model3 [8];

  always #5 clk = ~clk;

  apb_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .REG_NUM(8), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  apb_slave_regfile #(
    .ADDR_W(32), .DATA_W(32), .REG_NUM(8), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return a < 32'd32;
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef APB_SLVERR_EN
    return !in_rng(a);
`else
    return 1'b0;
`endif
  endfunction

  task automatic sample(input bit inst, output logic rdy, output logic [31:0] rd, output logic er);
    if (inst) begin rdy = pready3; rd = prdata3; er = pslverr3; end
    else      begin rdy = pready1; rd = prdata1; er = pslverr1; end
  endtask

  task automatic set_psel(input bit inst, input logic v);
    if (inst) psel3 = v; else psel1 = v;
  endtask

  // Full APB transfer; leaves the bus asserted so a following call runs back-to-back.
  task automatic xfer(input bit inst, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int unsigned wait_n;
    int unsigned n;
    bit          got;
    logic        rdy, er;
    logic [31:0] rd, exp_rd;
    logic [2:0]  idx;
    wait_n = inst ? 3 : 1;
    idx    = addr[4:2];
    @(posedge clk); #1;
    set_psel(inst, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    sample(inst, rdy, rd, er);
    check("pready_setup", {31'b0, rdy}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      sample(inst, rdy, rd, er);
      if (rdy) got = 1'b1;
      else     check("prdata_wait", rd, 32'd0);
    end
    if (!got) begin
      check("pready_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", n, wait_n + 1);
      exp_rd = 32'd0;
      if (!wr && in_rng(addr)) exp_rd = inst ? model3[idx] : model1[idx];
      check("prdata", rd, exp_rd);
      check("pslverr", {31'b0, er}, {31'b0, exp_err(addr)});
      if (wr && in_rng(addr)) begin
        if (inst) model3[idx] = data; else model1[idx] = data;
      end
    end
  endtask

  task automatic bus_idle();
    logic        rdy, er;
    logic [31:0] rd;
    @(posedge clk); #1;
    psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sample(k[0], rdy, rd, er);
      check("idle_pready", {31'b0, rdy}, 32'd0);
      check("idle_prdata", rd, 32'd0);
    end
  endtask

  task automatic read_all(input bit inst);
    for (int r = 0; r < 8; r++) begin
      xfer(inst, 1'b0, 32'(r * 4), 32'd0);
    end
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rdy, er;
    logic [31:0] rd;
    bit          inst, prev_inst;

    rst_n = 1'b0; psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int i = 0; i < 8; i++) begin model1[i] = '0; model3[i] = '0; end

    #12;
    check("rst_pready",  {31'b0, pready1},  32'd0);
    check("rst_prdata",  prdata1,           32'd0);
    check("rst_pslverr", {31'b0, pslverr1}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Write 8 to 0x04, then read it back
    xfer(1'b0, 1'b1, 32'h04, 32'h0000_0008);
    bus_idle();
    xfer(1'b0, 1'b0, 32'h04, 32'd0);
    check("reg1_is_8", prdata1, 32'h0000_0008);
    bus_idle();

    // Back-to-back write then read of 0x1C
    xfer(1'b0, 1'b1, 32'h1C, 32'hA5A5_A5A5);
    xfer(1'b0, 1'b0, 32'h1C, 32'd0);
    check("reg7_b2b", prdata1, 32'hA5A5_A5A5);
    bus_idle();

    // Out-of-range write and read
    xfer(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b0, 32'h20, 32'd0);
    bus_idle();
    read_all(1'b0);

    // penable without a setup phase is ignored in IDLE
    @(posedge clk); #1; psel1 = 1'b0; penable = 1'b1;
    repeat (3) begin @(negedge clk); check("idle_penable_only", {31'b0, pready1}, 32'd0); end
    @(posedge clk); #1; psel1 = 1'b1; penable = 1'b1;
    repeat (3) begin @(negedge clk); check("idle_psel_penable", {31'b0, pready1}, 32'd0); end
    bus_idle();

    // Abort: psel dropped during ACCESS on the WAIT_CYCLES=3 instance
    xfer(1'b1, 1'b1, 32'h08, 32'h0000_1234);
    bus_idle();
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFFFF_0000;
    @(posedge clk); #1; penable = 1'b1;
    repeat (2) begin @(negedge clk); check("abort_pre_pready", {31'b0, pready3}, 32'd0); end
    @(posedge clk); #1; psel3 = 1'b0; penable = 1'b0;
    repeat (5) begin @(negedge clk); check("abort_no_pready", {31'b0, pready3}, 32'd0); end
    xfer(1'b1, 1'b0, 32'h08, 32'd0);
    check("abort_reg_kept", prdata3, 32'h0000_1234);
    bus_idle();

    // Randomized traffic, including misaligned and out-of-range addresses
    prev_inst = 1'b0;
    for (int t = 0; t < 60; t++) begin
      inst = ($urandom_range(0, 3) == 0);
      if (inst != prev_inst) bus_idle();
      xfer(inst, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 43)), $urandom);
      if ($urandom_range(0, 1) == 1) bus_idle();
      prev_inst = inst;
    end
    bus_idle();
    read_all(1'b0);
    read_all(1'b1);

    // Reset asserted during the pready cycle of a read
    xfer(1'b0, 1'b1, 32'h0C, 32'h5A5A_0001);
    bus_idle();
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sample(1'b0, rdy, rd, er);
    check("prerst_pready", {31'b0, rdy}, 32'd1);
    check("prerst_prdata", rd, 32'h5A5A_0001);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pready",  {31'b0, pready1},  32'd0);
    check("midrst_prdata",  prdata1,           32'd0);
    check("midrst_pslverr", {31'b0, pslverr1}, 32'd0);
    psel1 = 1'b0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin model1[i] = '0; model3[i] = '0; end
    read_all(1'b0);
    read_all(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
